// File: rtl/cic_pkg.sv
// cic_pkg: shared constants, default compensation coefficients and FSM state type
// Holds the tap count, coefficient width, the inverse-sinc coefficient set and
// the comp_state_t encoding used by cic_comp_fir.
package cic_pkg;
  localparam int COMP_TAPS = 11;
  localparam int COMP_COEF_WIDTH = 18;
  // Symmetric inverse-sinc taps in Q1.17; element k multiplies x[n-k].
  localparam logic [COMP_TAPS-1:0][COMP_COEF_WIDTH-1:0] COMP_COEFS = {
    -18'sd300, 18'sd900, -18'sd2400, 18'sd6200, -18'sd16500, 18'sd120000,
    -18'sd16500, 18'sd6200, -18'sd2400, 18'sd900, -18'sd300
  };
  typedef enum logic [1:0] {IDLE, MAC, ROUND} comp_state_t;
endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: one-channel accumulator with half-up rounding and saturation
// Ports: clk_i/rst_i clock and async reset; clr_i zeroes the accumulator;
// en_i adds coef_i*x_i; round_i loads the rounded, saturated result into y_o.
module cic_comp_mac #(
  parameter int WIDTH = 16,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS = 11,
  parameter int FRAC_BITS = 17
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         round_i,
  input  logic signed [COEF_WIDTH-1:0] coef_i,
  input  logic signed [WIDTH-1:0]      x_i,
  output logic signed [WIDTH-1:0]      y_o
);
  localparam int AW = WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int PWD = WIDTH + COEF_WIDTH;
  localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [AW:0] MINV = -MAXV - (AW+1)'(1);
  logic signed [PWD-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW:0] rnd;
  logic signed [WIDTH-1:0] y_q, y_d;
  always_comb begin
    prod = PWD'(coef_i) * PWD'(x_i);
    acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
    // One guard bit keeps the rounding offset from overflowing the accumulator.
    rnd = ((AW+1)'(acc_q) + HALF) >>> FRAC_BITS;
    y_d = rnd > MAXV ? MAXV[WIDTH-1:0] : rnd < MINV ? MINV[WIDTH-1:0] : rnd[WIDTH-1:0];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      acc_q <= '0;
      y_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (round_i) y_q <= y_d;
    end
  assign y_o = y_q;
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: time-multiplexed I/Q inverse-sinc compensation FIR ahead of the CIC
// Ports: i_clock/i_reset clock and async active-high reset; i_inph_data/i_quad_data
// with i_ready strobe in; o_inph_data/o_quad_data held results with o_ready strobe;
// o_busy while computing; o_overrun sticky flag for strobes dropped while busy.
module cic_comp_fir
  import cic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int COEF_WIDTH = COMP_COEF_WIDTH,
  parameter int TAPS = COMP_TAPS,
  parameter int FRAC_BITS = 17,
  parameter logic [TAPS-1:0][COEF_WIDTH-1:0] COEFS = COMP_COEFS
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_inph_data,
  input  logic signed [WIDTH-1:0] i_quad_data,
  input  logic                    i_ready,
  output logic signed [WIDTH-1:0] o_inph_data,
  output logic signed [WIDTH-1:0] o_quad_data,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_overrun
);
  localparam int PW = $clog2(TAPS);
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);
  comp_state_t state_q;
  logic [PW-1:0] k_q, wr_ptr_q, wr_ptr_d, rd_q, rd_d;
  logic signed [WIDTH-1:0] dl_i_q [TAPS];
  logic signed [WIDTH-1:0] dl_q_q [TAPS];
  logic signed [COEF_WIDTH-1:0] coef;
  logic ready_q, ovr_q, accept;
  always_comb begin
    accept = state_q == IDLE && i_ready;
    wr_ptr_d = wr_ptr_q == LAST ? '0 : wr_ptr_q + PW'(1);
    rd_d = rd_q == '0 ? LAST : rd_q - PW'(1);
    coef = COEFS[k_q];
  end
  // rd_q starts at the slot just written and walks backwards, so tap k reads x[n-k].
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      k_q <= '0;
      wr_ptr_q <= '0;
      rd_q <= '0;
      ready_q <= 1'b0;
      ovr_q <= 1'b0;
      for (int t = 0; t < TAPS; t++) begin
        dl_i_q[t] <= '0;
        dl_q_q[t] <= '0;
      end
    end else begin
      ready_q <= state_q == ROUND;
      if (i_ready && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (i_ready) begin
          dl_i_q[wr_ptr_q] <= i_inph_data;
          dl_q_q[wr_ptr_q] <= i_quad_data;
          rd_q <= wr_ptr_q;
          wr_ptr_q <= wr_ptr_d;
          k_q <= '0;
          state_q <= MAC;
        end
        MAC: begin
          rd_q <= rd_d;
          if (k_q == LAST) state_q <= ROUND;
          else k_q <= k_q + PW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  cic_comp_mac #(.WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .FRAC_BITS(FRAC_BITS)) u_mac_i (
    .clk_i(i_clock), .rst_i(i_reset), .clr_i(accept), .en_i(state_q == MAC),
    .round_i(state_q == ROUND), .coef_i(coef), .x_i(dl_i_q[rd_q]), .y_o(o_inph_data)
  );
  cic_comp_mac #(.WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .FRAC_BITS(FRAC_BITS)) u_mac_q (
    .clk_i(i_clock), .rst_i(i_reset), .clr_i(accept), .en_i(state_q == MAC),
    .round_i(state_q == ROUND), .coef_i(coef), .x_i(dl_q_q[rd_q]), .y_o(o_quad_data)
  );
  assign o_ready = ready_q;
  assign o_busy = state_q != IDLE;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: randomized and directed checks of cic_comp_fir against a behavioural FIR model
module tb_cic_comp_fir;
  localparam int T = 11;
  localparam logic [T-1:0][17:0] C_IMP = {-18'sd65536, {9{18'd0}}, 18'd65536};
  localparam logic [T-1:0][17:0] C_RND = {{10{18'd0}}, 18'd65536};
  localparam logic [T-1:0][17:0] C_SAT = {11{18'd131071}};
  function automatic logic [T-1:0][17:0] cset(input int d);
    return d == 1 ? C_IMP : d == 2 ? C_RND : d == 3 ? C_SAT : cic_pkg::COMP_COEFS;
  endfunction
  logic clk = 0, rst = 1, rdy = 0;
  logic signed [15:0] di = 0, dq = 0;
  logic signed [15:0] oi [4];
  logic signed [15:0] oq [4];
  logic ordy [4];
  logic obusy [4];
  logic oovr [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    cic_comp_fir #(.COEFS(cset(g))) u (
      .i_clock(clk), .i_reset(rst), .i_inph_data(di), .i_quad_data(dq), .i_ready(rdy),
      .o_inph_data(oi[g]), .o_quad_data(oq[g]), .o_ready(ordy[g]), .o_busy(obusy[g]),
      .o_overrun(oovr[g])
    );
  end
  int cf [4][T];
  int hi [T];
  int hq [T];
  int ei [4], eq [4], pi [4], pq [4];
  int cnt = 0;
  bit er = 0, eovr = 0, mbusy;
  int errs = 0, checks = 0;
  int capi [4][$];
  int capq [4][$];
  function automatic int fir(input int d, input int h [T]);
    longint a = 0;
    for (int k = 0; k < T; k++) a += longint'(cf[d][k]) * longint'(h[k]);
    a = (a + 65536) >>> 17;
    return a > 32767 ? 32767 : a < -32768 ? -32768 : int'(a);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0; er = 0; eovr = 0;
      for (int k = 0; k < T; k++) begin hi[k] = 0; hq[k] = 0; end
      for (int d = 0; d < 4; d++) begin ei[d] = 0; eq[d] = 0; end
    end else begin
      mbusy = cnt > 0;
      er = 0;
      if (mbusy) begin
        cnt--;
        if (cnt == 0) begin
          er = 1;
          for (int d = 0; d < 4; d++) begin ei[d] = pi[d]; eq[d] = pq[d]; end
        end
      end
      if (rdy) begin
        if (mbusy) eovr = 1;
        else begin
          for (int k = T - 1; k > 0; k--) begin hi[k] = hi[k-1]; hq[k] = hq[k-1]; end
          hi[0] = di; hq[0] = dq;
          for (int d = 0; d < 4; d++) begin pi[d] = fir(d, hi); pq[d] = fir(d, hq); end
          cnt = T + 1;
        end
      end
    end
  end
  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, d, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("o_ready", d, int'(ordy[d]), int'(er));
      chk("o_busy", d, int'(obusy[d]), int'(cnt > 0));
      chk("o_overrun", d, int'(oovr[d]), int'(eovr));
      chk("o_inph_data", d, oi[d], ei[d]);
      chk("o_quad_data", d, oq[d], eq[d]);
      if (ordy[d]) begin capi[d].push_back(oi[d]); capq[d].push_back(oq[d]); end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input int i, input int q);
    di = 16'(i); dq = 16'(q); rdy = 1;
    @(negedge clk);
    rdy = 0;
  endtask
  task automatic clr_caps();
    for (int d = 0; d < 4; d++) begin capi[d].delete(); capq[d].delete(); end
  endtask
  task automatic do_reset();
    rst = 1;
    idle(2);
    rst = 0;
  endtask
  task automatic expect_seq(input string nm, input int d, input bit useq, input int exp [$]);
    int n;
    n = useq ? capq[d].size() : capi[d].size();
    chk({nm, "_count"}, d, n, exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk(nm, k, k < n ? (useq ? capq[d][k] : capi[d][k]) : -99999, exp[k]);
  endtask
  task automatic impulse();
    clr_caps();
    strobe(1000, -1000); idle(19);
    repeat (11) begin strobe(0, 0); idle(19); end
    expect_seq("impulse_i", 1, 0, '{500, 0, 0, 0, 0, 0, 0, 0, 0, 0, -500, 0});
    expect_seq("impulse_q", 1, 1, '{-500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 500, 0});
  endtask
  initial begin
    for (int d = 0; d < 4; d++) begin
      logic [T-1:0][17:0] c;
      c = cset(d);
      for (int k = 0; k < T; k++) cf[d][k] = int'($signed(c[k]));
    end
    idle(2);
    rst = 0;
    for (int d = 0; d < 4; d++) begin
      chk("reset_inph", d, oi[d], 0);
      chk("reset_quad", d, oq[d], 0);
      chk("reset_busy", d, int'(obusy[d]), 0);
      chk("reset_overrun", d, int'(oovr[d]), 0);
    end
    impulse();
    clr_caps();
    foreach (C_RND[j]) begin end
    begin
      int rv [4] = '{3, -3, 1, -1};
      for (int j = 0; j < 4; j++) begin strobe(rv[j], -rv[j]); idle(19); end
    end
    expect_seq("round_i", 2, 0, '{2, -1, 1, 0});
    expect_seq("round_q", 2, 1, '{-1, 2, 0, 1});
    clr_caps();
    repeat (11) begin strobe(32767, -32768); idle(19); end
    repeat (11) begin strobe(-32768, 32767); idle(19); end
    chk("sat_count", 3, capi[3].size(), 22);
    if (capi[3].size() == 22) begin
      for (int k = 0; k < 11; k++) begin
        chk("sat_hi", k, capi[3][k], 32767);
        chk("sat_lo_q", k, capq[3][k], -32768);
      end
      chk("sat_lo", 21, capi[3][21], -32768);
      chk("sat_hi_q", 21, capq[3][21], 32767);
    end
    clr_caps();
    repeat (25) begin strobe(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768); idle(12); end
    idle(20);
    chk("b2b_overrun", 0, int'(oovr[0]), 0);
    chk("b2b_count", 0, capi[0].size(), 25);
    repeat (40) begin strobe(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768); idle($urandom_range(3, 20)); end
    idle(20);
    do_reset();
    clr_caps();
    strobe(3, 0); idle(4); strobe(101, 0); idle(30);
    chk("ovr_flag", 2, int'(oovr[2]), 1);
    chk("ovr_ready_count", 2, capi[2].size(), 1);
    if (capi[2].size() == 1) chk("ovr_value", 2, capi[2][0], 2);
    do_reset();
    clr_caps();
    strobe(1000, -1000); idle(3);
    do_reset();
    idle(20);
    chk("midrst_ready_count", 1, capi[1].size(), 0);
    chk("midrst_busy", 1, int'(obusy[1]), 0);
    chk("midrst_inph", 1, oi[1], 0);
    chk("midrst_quad", 1, oq[1], 0);
    impulse();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Inverse-sinc compensation FIR sitting directly upstream of the CIC interpolator. It filters the low-rate complex (I/Q) sample stream so that, after CIC interpolation, the passband droop of the CIC is flattened. The MAC is time-multiplexed: one multiplier per channel iterates over all taps for each input sample. This is acceptable because input samples arrive once per interpolation period, which is hundreds of clocks.

## Interface
- WIDTH, 16: signed sample width, input and output.
- COEF_WIDTH, 18: signed coefficient width.
- TAPS, 11: number of FIR taps; must be ≥ 2.
- FRAC_BITS, 17: coefficient fractional bits; the result is shifted right by this amount.
- COEFS, cic_pkg::COMP_COEFS: TAPS signed coefficients, element k applied to x[n-k].

- i_clock  in  1  sole clock.
- i_reset  in  1  reset, asynchronous, active-high.
- i_inph_data  in  WIDTH  in-phase input sample, signed.
- i_quad_data  in  WIDTH  quadrature input sample, signed.
- i_ready  in  1  input strobe; sample valid this cycle.
- o_inph_data  out  WIDTH  filtered in-phase output, held between results.
- o_quad_data  out  WIDTH  filtered quadrature output, held between results.
- o_ready  out  1  one-cycle strobe; new output present.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_overrun  out  1  sticky; set when a strobe arrives while busy.

## Operation
- **FSM states:** IDLE, MAC, ROUND.
- **IDLE:**
  - Triggered when i_ready=1.
  - Write I/Q into the circular delay line at wr_ptr. wr_ptr wraps TAPS-1 → 0.
  - Clear both accumulators, set k=0, go to MAC.
- **MAC:**
  - Each cycle, acc += COEFS[k] * x[n-k], with x[n-k] read at (wr_ptr_of_sample - k) mod TAPS.
  - k increments; after k=TAPS-1, go to ROUND.
  - Occupies exactly TAPS cycles.
- **ROUND:**
  - Compute y = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS. Rounding is half-up toward +inf.
  - Saturate y to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register into o_*_data, pulse o_ready, go to IDLE.
- **Accumulator width:** WIDTH + COEF_WIDTH + $clog2(TAPS), signed, so there is no internal overflow. Saturation happens only at ROUND.
- **Channels:** I and Q are computed in lockstep with identical coefficients.
- **Strobe while busy (MAC or ROUND):**
  - The sample is discarded and the delay line is untouched.
  - o_overrun is set and stays set until reset.
  - The computation in progress is unaffected.
- **Strobe in IDLE on the same cycle o_ready is high:** accepted normally.

## Timing
- **Reset values:**
  - o_inph_data = 0, o_quad_data = 0, o_ready = 0, o_busy = 0, o_overrun = 0.
  - Delay line all zero, wr_ptr = 0, state = IDLE.
- **Reset asserted mid-operation:** aborts immediately and asynchronously. No o_ready pulse follows, and outputs return to 0.
- **Latency:** if i_ready is sampled at edge E, o_ready is high for exactly the one cycle following edge E+TAPS+1, and the new o_*_data appears at that same edge.
- **o_busy:** high from edge E to edge E+TAPS+1.
- **Throughput:** minimum accepted input spacing is TAPS+2 clocks; an earlier strobe counts as an overrun.
- **Downstream hold:** o_*_data stays stable until the next o_ready, so the downstream comb samples valid data on its own sample strobe.

## Structure
- **cic_pkg holds:**
  - COMP_TAPS
  - COMP_COEF_WIDTH
  - COMP_COEFS constant array
  - typedef enum logic [1:0] {IDLE, MAC, ROUND} comp_state_t
- **Sub-module cic_comp_mac:**
  - One channel: accumulator, clear/accumulate control, and round/saturate.
  - Instantiated twice (I, Q). The FSM, pointer, tap index and delay-line addressing stay in the top level.

## Test plan
- **Impulse response:**
  - Stimulus: COEFS = {65536, 0, …, 0, -65536} (0.5 at tap 0, -0.5 at tap TAPS-1); I=1000 once, then zeros at spacing 20.
  - Required: outputs 500, then 0 ×9, then -500, then 0. Q driven with -1000 mirrors this with opposite signs.
- **Rounding:**
  - Stimulus: COEFS[0] = 65536, rest 0.
  - Required: input 3 → 2; input -3 → -1; input 1 → 1; input -1 → 0.
- **Saturation:**
  - Stimulus: all COEFS = 131071; hold input at 32767 for 11 samples, then at -32768 for 11 samples.
  - Required: outputs reach and stay at 32767, then at -32768. No wrap at any sample.
- **Overrun:**
  - Stimulus: strobe at edge 0, then again at edge 5.
  - Required: o_overrun = 1 from edge 6 onward; exactly one o_ready, at edge TAPS+1; second sample absent from later outputs.
- **Back-to-back and wrap:**
  - Stimulus: 25 strobes at exact spacing TAPS+2.
  - Required: no overrun; results match a golden model across two wr_ptr wraps.
- **Reset mid-MAC:**
  - Stimulus: assert i_reset at cycle E+4 for 2 cycles.
  - Required: outputs 0, no o_ready, o_busy 0. The next impulse reproduces the clean impulse response, confirming the delay line was cleared.
